// File: rtl/logic_xor_arb_if.sv
// logic_xor_arb_if: requester beat bundle and checksum result port of logic_xor_arb.
// ovG_res_count exists only when LOGIC_XOR_ARB_COUNT_EN is defined.
interface logic_xor_arb_if #(
    parameter int PAR_DATA_BITS = 8,
    parameter int PAR_REQ       = 4,
    parameter int PAR_ID_BITS   = 2,
    parameter int PAR_CNT_BITS  = 8
);
    logic [PAR_REQ-1:0]               ivG_req_valid;
    logic [PAR_REQ-1:0]               ivG_req_last;
    logic [PAR_REQ*PAR_DATA_BITS-1:0] ivG_req_data;
    logic [PAR_REQ-1:0]               ovG_req_ready;
    logic [PAR_DATA_BITS-1:0]         ovG_res_data;
    logic [PAR_ID_BITS-1:0]           ovG_res_id;
    logic                             ob_res_valid;
    logic                             ib_res_ready;
    logic                             ob_busy;
`ifdef LOGIC_XOR_ARB_COUNT_EN
    logic [PAR_CNT_BITS-1:0]          ovG_res_count;
`endif
    modport master (
        output ivG_req_valid, ivG_req_last, ivG_req_data, ib_res_ready,
        input  ovG_req_ready, ovG_res_data, ovG_res_id, ob_res_valid, ob_busy
`ifdef LOGIC_XOR_ARB_COUNT_EN
        , input ovG_res_count
`endif
    );
    modport slave (
        input  ivG_req_valid, ivG_req_last, ivG_req_data, ib_res_ready,
        output ovG_req_ready, ovG_res_data, ovG_res_id, ob_res_valid, ob_busy
`ifdef LOGIC_XOR_ARB_COUNT_EN
        , output ovG_res_count
`endif
    );
endinterface

// File: rtl/logic_xor_arb.sv
// logic_xor_arb: round-robin arbiter sharing one XOR-accumulate checksum engine among requesters.
// Define LOGIC_XOR_ARB_COUNT_EN to add a saturating per-burst beat count to each result.
module logic_xor_arb #(
    parameter int PAR_DATA_BITS = 8,
    parameter int PAR_REQ       = 4,
    parameter int PAR_ID_BITS   = 2,
    parameter int PAR_CNT_BITS  = 8
) (
    input logic             ib_clk,
    input logic             ib_rst,
    logic_xor_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, BURST, RESULT} state_t;
    state_t                   state_q, state_d;
    logic [PAR_ID_BITS-1:0]   grant_q, grant_d, ptr_q, ptr_d, res_id_q, res_id_d;
    logic [PAR_ID_BITS-1:0]   pick_idx, idx;
    logic                     pick_found, beat;
    logic [PAR_DATA_BITS-1:0] acc_q, acc_d, res_data_q, res_data_d, beat_data;
`ifdef LOGIC_XOR_ARB_COUNT_EN
    logic [PAR_CNT_BITS-1:0]  cnt_q, cnt_d, cnt_inc, res_count_q, res_count_d;
`endif

    // Walk down the offsets so the requester closest to the pointer is written last and wins.
    always_comb begin
        pick_found = 1'b0;
        pick_idx = '0;
        idx = '0;
        for (int i = PAR_REQ - 1; i >= 0; i--) begin
            idx = PAR_ID_BITS'((int'(ptr_q) + i) % PAR_REQ);
            if (bus.ivG_req_valid[idx]) begin
                pick_found = 1'b1;
                pick_idx = idx;
            end
        end
    end

    assign beat_data = bus.ivG_req_data[grant_q*PAR_DATA_BITS +: PAR_DATA_BITS];
    assign beat = (state_q == BURST) && bus.ivG_req_valid[grant_q];
`ifdef LOGIC_XOR_ARB_COUNT_EN
    assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d = ptr_q;
        acc_d = acc_q;
        res_data_d = res_data_q;
        res_id_d = res_id_q;
`ifdef LOGIC_XOR_ARB_COUNT_EN
        cnt_d = cnt_q;
        res_count_d = res_count_q;
`endif
        case (state_q)
            IDLE: if (pick_found) begin
                grant_d = pick_idx;
                acc_d = '0;
`ifdef LOGIC_XOR_ARB_COUNT_EN
                cnt_d = '0;
`endif
                state_d = BURST;
            end
            BURST: if (beat) begin
                acc_d = acc_q ^ beat_data;
`ifdef LOGIC_XOR_ARB_COUNT_EN
                cnt_d = cnt_inc;
`endif
                if (bus.ivG_req_last[grant_q]) begin
                    res_data_d = acc_q ^ beat_data;
                    res_id_d = grant_q;
`ifdef LOGIC_XOR_ARB_COUNT_EN
                    res_count_d = cnt_inc;
`endif
                    state_d = RESULT;
                end
            end
            RESULT: if (bus.ib_res_ready) begin
                state_d = IDLE;
                ptr_d = (grant_q == PAR_ID_BITS'(PAR_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ib_clk) begin
        if (ib_rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q <= '0;
            acc_q <= '0;
            res_data_q <= '0;
            res_id_q <= '0;
`ifdef LOGIC_XOR_ARB_COUNT_EN
            cnt_q <= '0;
            res_count_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q <= ptr_d;
            acc_q <= acc_d;
            res_data_q <= res_data_d;
            res_id_q <= res_id_d;
`ifdef LOGIC_XOR_ARB_COUNT_EN
            cnt_q <= cnt_d;
            res_count_q <= res_count_d;
`endif
        end
    end

    assign bus.ovG_req_ready = (state_q == BURST) ? (PAR_REQ'(1) << grant_q) : '0;
    assign bus.ob_res_valid = state_q == RESULT;
    assign bus.ob_busy = state_q != IDLE;
    assign bus.ovG_res_data = res_data_q;
    assign bus.ovG_res_id = res_id_q;
`ifdef LOGIC_XOR_ARB_COUNT_EN
    assign bus.ovG_res_count = res_count_q;
`endif
endmodule

// File: tb/tb_logic_xor_arb.sv
// tb_logic_xor_arb: directed and random bursts; a round-robin model predicts the result order,
// and a monitor process pops expectations on every result handshake.
module tb_logic_xor_arb;
    localparam int W = 8, N = 4, IB = 2, CB = 8;

    typedef struct {logic [W-1:0] data; logic last; int gap;} beat_t;
    typedef struct {int id; logic [W-1:0] data; int cnt;} res_t;

    logic clk = 1'b0, rst = 1'b1;
    beat_t bq[N][$];
    res_t sb[$];
    int checks = 0, errors = 0, m_ptr = 0, rr_mode = 0;

    logic_xor_arb_if #(.PAR_DATA_BITS(W), .PAR_REQ(N), .PAR_ID_BITS(IB), .PAR_CNT_BITS(CB)) bus();
    logic_xor_arb #(.PAR_DATA_BITS(W), .PAR_REQ(N), .PAR_ID_BITS(IB), .PAR_CNT_BITS(CB)) dut (
        .ib_clk(clk), .ib_rst(rst), .bus(bus));

    initial forever #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    task automatic add_beat(int r, logic [W-1:0] d, logic last, int gap);
        beat_t b;
        b.data = d;
        b.last = last;
        b.gap = gap;
        bq[r].push_back(b);
    endtask

    task automatic expect_res(int id, logic [W-1:0] d, int cnt);
        res_t e;
        e.id = id;
        e.data = d;
        e.cnt = cnt;
        sb.push_back(e);
        m_ptr = (id + 1) % N;
    endtask

    function automatic bit beats_pending();
        for (int i = 0; i < N; i++) if (bq[i].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while ((sb.size() != 0 || bus.ob_busy !== 1'b0 || beats_pending()) && n < 2000) begin
            step();
            n++;
        end
        checks++;
        if (n >= 2000) begin
            errors++;
            $display("FAIL %s timeout: %0d results outstanding, expected 0", name, sb.size());
        end
    endtask

    // Requester drivers: present queue heads, honour gaps, retire beats that will be accepted.
    initial begin
        logic [N-1:0] v, l, fire;
        logic [N*W-1:0] d;
        beat_t b;
        forever begin
            @(negedge clk);
            bus.ib_res_ready = (rr_mode == 0) || (rr_mode == 1 && $urandom_range(0, 1) == 1);
            v = '0;
            l = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
                if (bq[i].size() != 0) begin
                    b = bq[i][0];
                    if (b.gap > 0) begin
                        b.gap--;
                        bq[i][0] = b;
                    end else begin
                        v[i] = 1'b1;
                        l[i] = b.last;
                        d[i*W +: W] = b.data;
                    end
                end
            end
            bus.ivG_req_valid = v;
            bus.ivG_req_last = l;
            bus.ivG_req_data = d;
            fire = v & bus.ovG_req_ready;
            if (!rst) for (int i = 0; i < N; i++) if (fire[i]) void'(bq[i].pop_front());
        end
    end

    // Monitor: every accepted result is compared against the oldest expectation.
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.ob_res_valid === 1'b1 && bus.ib_res_ready === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got id %0d data 0x%0h, expected none",
                             bus.ovG_res_id, bus.ovG_res_data);
                end else begin
                    e = sb.pop_front();
                    chk("res_id", 32'(bus.ovG_res_id), 32'(e.id));
                    chk("res_data", 32'(bus.ovG_res_data), 32'(e.data));
`ifdef LOGIC_XOR_ARB_COUNT_EN
                    chk("res_count", 32'(bus.ovG_res_count), 32'(e.cnt));
`endif
                end
            end
        end
    end

    initial begin
        int c, n, r, len, found;
        logic [W-1:0] x, dv;
        res_t pend[N][$];
        res_t p;
        // Reset with every requester asking; then one-beat bursts in round-robin order.
        for (int i = 0; i < N; i++) add_beat(i, 8'(1 << i), 1'b1, 0);
        add_beat(0, 8'h10, 1'b1, 0);
        expect_res(0, 8'h01, 1);
        expect_res(1, 8'h02, 1);
        expect_res(2, 8'h04, 1);
        expect_res(3, 8'h08, 1);
        expect_res(0, 8'h10, 1);
        repeat (2) begin
            step();
            chk("rst_ready", 32'(bus.ovG_req_ready), 32'h0);
            chk("rst_res_valid", 32'(bus.ob_res_valid), 32'h0);
            chk("rst_busy", 32'(bus.ob_busy), 32'h0);
        end
        chk("rst_res_data", 32'(bus.ovG_res_data), 32'h0);
        chk("rst_res_id", 32'(bus.ovG_res_id), 32'h0);
        rst = 1'b0;
        wait_done("rr_order");

        // Req1 three-beat burst with a stalled result consumer; req0 waits behind it.
        rr_mode = 2;
        add_beat(1, 8'h0F, 1'b0, 0);
        add_beat(1, 8'hF0, 1'b0, 0);
        add_beat(1, 8'h33, 1'b1, 0);
        add_beat(0, 8'h3C, 1'b1, 0);
        expect_res(1, 8'hCC, 3);
        expect_res(0, 8'h3C, 1);
        c = 0;
        while (bus.ob_res_valid !== 1'b1 && c < 50) begin
            step();
            c++;
            if (c == 2) chk("first_grant_ready", 32'(bus.ovG_req_ready), 32'h2);
        end
        chk("result_latency", 32'(c), 32'd5);
        repeat (5) begin
            step();
            chk("stall_valid", 32'(bus.ob_res_valid), 32'h1);
            chk("stall_data", 32'(bus.ovG_res_data), 32'hCC);
            chk("stall_id", 32'(bus.ovG_res_id), 32'h1);
            chk("stall_ready", 32'(bus.ovG_req_ready), 32'h0);
        end
        rr_mode = 0;
        wait_done("stall");

        // Req2 burst with a 3-cycle gap while req0 keeps asking.
        add_beat(2, 8'hAA, 1'b0, 0);
        add_beat(2, 8'h55, 1'b1, 3);
        add_beat(0, 8'h77, 1'b1, 0);
        expect_res(2, 8'hFF, 2);
        expect_res(0, 8'h77, 1);
        wait_done("gap");

        // Reset in the middle of a req3 burst drops it and rewinds the pointer to 0.
        add_beat(3, 8'h11, 1'b0, 0);
        n = 0;
        while (bq[3].size() != 0 && n < 50) begin
            step();
            n++;
        end
        step();
        chk("midburst_busy", 32'(bus.ob_busy), 32'h1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        m_ptr = 0;
        chk("midrst_busy", 32'(bus.ob_busy), 32'h0);
        chk("midrst_ready", 32'(bus.ovG_req_ready), 32'h0);
        chk("midrst_res_valid", 32'(bus.ob_res_valid), 32'h0);
        add_beat(3, 8'h12, 1'b1, 0);
        add_beat(1, 8'hA5, 1'b1, 0);
        add_beat(0, 8'h5A, 1'b1, 0);
        expect_res(0, 8'h5A, 1);
        expect_res(1, 8'hA5, 1);
        expect_res(3, 8'h12, 1);
        wait_done("post_reset");

        // Random bursts; the model serves pending requesters round-robin from m_ptr.
        rr_mode = 1;
        repeat (40) begin
            r = $urandom_range(0, N - 1);
            len = $urandom_range(1, 4);
            x = '0;
            for (int b = 0; b < len; b++) begin
                dv = 8'($urandom);
                x ^= dv;
                add_beat(r, dv, b == len - 1,
                         (b != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            end
            p.id = r;
            p.data = x;
            p.cnt = len;
            pend[r].push_back(p);
        end
        found = 1;
        while (found != 0) begin
            found = 0;
            for (int k = 0; k < N && found == 0; k++) begin
                if (pend[(m_ptr + k) % N].size() != 0) begin
                    p = pend[(m_ptr + k) % N].pop_front();
                    expect_res(p.id, p.data, p.cnt);
                    found = 1;
                end
            end
        end
        wait_done("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
